pe_stream_feeder: RTL and testbench

- Global-buffer-side driver for one convolution PE: the sending end of the PE's weight/activation interface.
- Loads the 5 filter taps into the PE, then streams input-activation samples from an upstream valid/ready source.
- Generates the PE's start, 0..4 tap counter and state code; sits between the global buffer and the PE in the ECG 1-D conv datapath.

---
 rtl/pe_stream_feeder_if.sv | 40 ++++
 rtl/pe_stream_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_pe_stream_feeder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_stream_feeder_if.sv
// Bus between the global-buffer side (weights, commands, upstream samples) and
// the PE-facing outputs of pe_stream_feeder. The master modport is the feeder.
interface pe_stream_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
);
  logic                         w_wr_en;
  logic [2:0]                   w_wr_addr;
  logic signed [DATA_WIDTH-1:0] w_wr_data;
  logic                         cmd_start;
  logic [LEN_WIDTH-1:0]         cmd_len;
  // Upstream handshake: a sample transfers on any cycle where s_valid && s_ready.
  logic                         s_valid;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic                         s_ready;
  logic                         start_out;
  logic [2:0]                   ctrl_counter_out;
  logic [2:0]                   current_state_out;
  logic                         filter_valid_out;
  logic signed [DATA_WIDTH-1:0] filter_out;
  logic                         ia_valid_out;
  logic signed [DATA_WIDTH-1:0] ia_out;
  logic                         hold_out;
  logic                         busy_out;
  logic                         done_out;

  modport master (
    input  w_wr_en, w_wr_addr, w_wr_data, cmd_start, cmd_len, s_valid, s_data,
    output s_ready, start_out, ctrl_counter_out, current_state_out,
           filter_valid_out, filter_out, ia_valid_out, ia_out,
           hold_out, busy_out, done_out
  );

  modport slave (
    output w_wr_en, w_wr_addr, w_wr_data, cmd_start, cmd_len, s_valid, s_data,
    input  s_ready, start_out, ctrl_counter_out, current_state_out,
           filter_valid_out, filter_out, ia_valid_out, ia_out,
           hold_out, busy_out, done_out
  );
endinterface

// File: rtl/pe_stream_feeder.sv
// Drives one conv PE: loads 5 filter taps, then streams FIFO'd samples one per tap sweep.
// Define PE_FEEDER_ZERO_PAD_EN to add the DRAIN state that flushes the PE window with zeros.
module pe_stream_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_stream_feeder_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [2:0]           LAST_TAP = 3'(KERNEL_SIZE - 1);
  localparam logic [2:0]           WAIT_TAP = 3'(KERNEL_SIZE - 2);
  localparam logic [PTR_W:0]       CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]       CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                       state_q;
  logic [2:0]                   cnt_q;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [LEN_WIDTH-1:0]         sent_q;
  logic signed [DATA_WIDTH-1:0] wtable_q [KERNEL_SIZE];
`ifdef PE_FEEDER_ZERO_PAD_EN
  logic [2:0]                   zeros_q;
`endif

  logic                         start_q, fvalid_q, ia_valid_q, hold_q, done_q;
  logic signed [DATA_WIDTH-1:0] filter_q, ia_q;

  logic signed [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]               count_q, count_d;
  logic                         full, empty, push, pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = bus.s_valid && !full;
  // The sample for a sweep leaves the FIFO as the counter steps 3->4.
  assign pop   = (state_q == STREAM) && (cnt_q == WAIT_TAP) && !empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KERNEL_SIZE; i++) wtable_q[i] <= '0;
    end else if (bus.w_wr_en && (state_q == IDLE) && (bus.w_wr_addr < 3'(KERNEL_SIZE))) begin
      wtable_q[bus.w_wr_addr] <= bus.w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      sent_q     <= '0;
      start_q    <= 1'b0;
      fvalid_q   <= 1'b0;
      filter_q   <= '0;
      ia_valid_q <= 1'b0;
      ia_q       <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PE_FEEDER_ZERO_PAD_EN
      zeros_q    <= '0;
`endif
    end else begin
      start_q    <= 1'b0;
      fvalid_q   <= 1'b0;
      filter_q   <= '0;
      ia_valid_q <= 1'b0;
      ia_q       <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_start) begin
            state_q  <= LOAD_W;
            cnt_q    <= '0;
            len_q    <= bus.cmd_len;
            sent_q   <= '0;
            start_q  <= 1'b1;
            fvalid_q <= 1'b1;
            filter_q <= wtable_q[0];
          end
        end
        LOAD_W: begin
          if (cnt_q == LAST_TAP) begin
            cnt_q <= '0;
            if (len_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= STREAM;
            end
          end else begin
            cnt_q    <= cnt_q + 3'd1;
            start_q  <= 1'b1;
            fvalid_q <= 1'b1;
            filter_q <= wtable_q[cnt_q + 3'd1];
          end
        end
        STREAM: begin
          if (cnt_q == WAIT_TAP) begin
            if (pop) begin
              cnt_q      <= LAST_TAP;
              ia_valid_q <= 1'b1;
              ia_q       <= mem_q[rd_ptr_q];
              sent_q     <= sent_q + LEN_ONE;
            end else begin
              hold_q <= (count_d == '0);
            end
          end else if (cnt_q == LAST_TAP) begin
            cnt_q <= '0;
            if (sent_q == len_q) begin
`ifdef PE_FEEDER_ZERO_PAD_EN
              state_q <= DRAIN;
              zeros_q <= '0;
`else
              state_q <= DONE;
              done_q  <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
            // hold_out mirrors the cycle in which counter=3 finds the FIFO empty.
            hold_q <= ((cnt_q + 3'd1) == WAIT_TAP) && (count_d == '0);
          end
        end
`ifdef PE_FEEDER_ZERO_PAD_EN
        DRAIN: begin
          if (cnt_q == WAIT_TAP) begin
            cnt_q      <= LAST_TAP;
            ia_valid_q <= 1'b1;
            ia_q       <= '0;
            zeros_q    <= zeros_q + 3'd1;
          end else if (cnt_q == LAST_TAP) begin
            cnt_q <= '0;
            if (zeros_q == LAST_TAP) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.s_ready           = !full;
  assign bus.start_out         = start_q;
  assign bus.ctrl_counter_out  = cnt_q;
  assign bus.current_state_out = state_q;
  assign bus.filter_valid_out  = fvalid_q;
  assign bus.filter_out        = filter_q;
  assign bus.ia_valid_out      = ia_valid_q;
  assign bus.ia_out            = ia_q;
  assign bus.hold_out          = hold_q;
  assign bus.busy_out          = (state_q != IDLE);
  assign bus.done_out          = done_q;
endmodule

// File: tb/tb_pe_stream_feeder.sv
// Scoreboard bench for pe_stream_feeder: drivers queue expected taps/samples,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_pe_stream_feeder;
  localparam int DW = 16;
  localparam int LW = 16;
  localparam int CW = DW + 3;
`ifdef PE_FEEDER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;

  pe_stream_feeder_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  pe_stream_feeder #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(5), .FIFO_DEPTH(4), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [DW-1:0]        exp_q[$];
  logic [CW-1:0]        exp_w_q[$];
  logic signed [DW-1:0] wt_model [5];
  int                   ia_cyc_q[$];
  int                   done_cnt = 0, hold_cnt = 0, done_cyc = 0, last_ia_cyc = 0;
  bit                   state3_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] got;
    logic [CW-1:0] wexp;
    if (rst_n) begin
      if (bus.ia_valid_out) begin
        got = bus.ia_out;
        check("ia_counter", 32'(bus.ctrl_counter_out), 32'd4);
        if (exp_q.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL ia_unexpected actual=%0h required=none (cycle %0d)", got, cyc);
        end else begin
          check("ia_out", 32'(got), 32'(exp_q.pop_front()));
        end
        ia_cyc_q.push_back(cyc);
        last_ia_cyc = cyc;
      end
      if (bus.filter_valid_out) begin
        got = bus.filter_out;
        if (exp_w_q.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL filter_unexpected actual=%0h required=none (cycle %0d)", got, cyc);
        end else begin
          wexp = exp_w_q.pop_front();
          check("filter_counter", 32'(bus.ctrl_counter_out), 32'(wexp[CW-1:DW]));
          check("filter_out", 32'(got), 32'(wexp[DW-1:0]));
          check("filter_start", 32'(bus.start_out), 32'd1);
        end
      end
      if (bus.hold_out) begin
        hold_cnt++;
        check("hold_counter", 32'(bus.ctrl_counter_out), 32'd3);
      end
      if (bus.done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.current_state_out == 3'd3) state3_seen = 1'b1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [2:0] a, input logic signed [DW-1:0] d, input bit track);
    bus.w_wr_en = 1'b1; bus.w_wr_addr = a; bus.w_wr_data = d;
    tick();
    bus.w_wr_en = 1'b0;
    if (track && a < 3'd5) wt_model[a] = d;
  endtask

  task automatic push_sample(input logic signed [DW-1:0] d);
    int n = 0;
    bus.s_valid = 1'b1; bus.s_data = d;
    while (!bus.s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.s_ready) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL push_timeout actual=s_ready_low required=s_ready_high (cycle %0d)", cyc);
    end else begin
      exp_q.push_back(d);
    end
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic start_run(input logic [LW-1:0] len);
    for (int i = 0; i < 5; i++) exp_w_q.push_back({3'(i), wt_model[i]});
    bus.cmd_start = 1'b1; bus.cmd_len = len;
    tick();
    bus.cmd_start = 1'b0;
    check("load_latency_state", 32'(bus.current_state_out), 32'd1);
  endtask

  task automatic expect_drain();
    if (PAD) for (int i = 0; i < 4; i++) exp_q.push_back('0);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL done_timeout actual=no_done required=done (cycle %0d)", cyc);
    end
  endtask

  task automatic wait_cnt3(input string name);
    int n = 0;
    while (!(bus.current_state_out == 3'd2 && bus.ctrl_counter_out == 3'd3) && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(bus.ctrl_counter_out), 32'd3);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 32'({bus.start_out, bus.ctrl_counter_out, bus.current_state_out,
                                bus.filter_valid_out, bus.ia_valid_out, bus.hold_out,
                                bus.busy_out, bus.done_out}), 32'd0);
    check({name, "_data"}, 32'({bus.filter_out, bus.ia_out}), 32'd0);
    check({name, "_s_ready"}, 32'(bus.s_ready), 32'd1);
  endtask

  initial begin
    int d0;
    int n;
    int ia0;
    bus.w_wr_en = 1'b0; bus.w_wr_addr = '0; bus.w_wr_data = '0;
    bus.cmd_start = 1'b0; bus.cmd_len = '0; bus.s_valid = 1'b0; bus.s_data = '0;
    for (int i = 0; i < 5; i++) wt_model[i] = '0;

    // reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_state", 32'(bus.current_state_out), 32'd0);

    // taps 1..5, len=3, samples fed after start
    for (int i = 0; i < 5; i++) write_w(3'(i), 16'(i + 1), 1'b1);
    write_w(3'd5, 16'sd77, 1'b1);
    d0 = done_cnt;
    start_run(16'd3);
    check("t1_start_out", 32'(bus.start_out), 32'd1);
    check("t1_busy", 32'(bus.busy_out), 32'd1);
    push_sample(16'sd7);
    push_sample(16'sd8);
    push_sample(16'sd9);
    expect_drain();
    wait_done(300);
    repeat (3) tick();
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_idle_busy", 32'(bus.busy_out), 32'd0);

    // preload full FIFO, len=4, samples 5 cycles apart without stalls
    hold_cnt = 0;
    ia_cyc_q.delete();
    push_sample(16'sd10);
    push_sample(-16'sd20);
    push_sample(16'sd30);
    push_sample(16'sd40);
    check("t2_s_ready_full", 32'(bus.s_ready), 32'd0);
    start_run(16'd4);
    expect_drain();
    wait_done(300);
    check("t2_no_hold", 32'(hold_cnt), 32'd0);
    check("t2_ia_count", 32'(ia_cyc_q.size() >= 4), 32'd1);
    for (int i = 1; i < 4; i++)
      if (i < ia_cyc_q.size()) check("t2_ia_gap", 32'(ia_cyc_q[i] - ia_cyc_q[i-1]), 32'd5);
    check("t2_s_ready_free", 32'(bus.s_ready), 32'd1);

    // empty FIFO at counter=3 for 7 cycles
    hold_cnt = 0;
    start_run(16'd1);
    wait_cnt3("t3_reach_cnt3");
    repeat (6) tick();
    push_sample(16'sd55);
    expect_drain();
    wait_done(300);
    check("t3_hold_cycles", 32'(hold_cnt), 32'd7);

    // len=0, second cmd_start during LOAD_W ignored
    d0 = done_cnt;
    ia_cyc_q.delete();
    start_run(16'd0);
    bus.cmd_start = 1'b1; bus.cmd_len = 16'd5;
    tick();
    bus.cmd_start = 1'b0;
    wait_done(50);
    repeat (8) tick();
    check("t4_done_once", 32'(done_cnt - d0), 32'd1);
    check("t4_no_ia", 32'(ia_cyc_q.size()), 32'd0);
    check("t4_idle", 32'(bus.current_state_out), 32'd0);
    // weight write in STREAM must not land; next load shows the old taps
    start_run(16'd1);
    wait_cnt3("t4_reach_stream");
    write_w(3'd0, 16'sd99, 1'b0);
    push_sample(16'sd66);
    expect_drain();
    wait_done(300);
    start_run(16'd0);
    wait_done(50);

    // len=2: done follows the last ia pulse (zero-pad pulses when enabled)
    state3_seen = 1'b0;
    push_sample(16'sd5);
    push_sample(16'sd6);
    start_run(16'd2);
    expect_drain();
    wait_done(300);
    check("t5_done_after_last_ia", 32'(done_cyc - last_ia_cyc), 32'd1);
    check("t5_state3_seen", 32'(state3_seen), 32'(PAD));

    // reset mid-STREAM discards the run, the FIFO and the weight table
    push_sample(16'sd1);
    push_sample(16'sd2);
    push_sample(16'sd3);
    push_sample(16'sd4);
    start_run(16'd8);
    ia0 = ia_cyc_q.size();
    n = 0;
    while (ia_cyc_q.size() < ia0 + 2 && n < 200) begin
      tick();
      n++;
    end
    check("t6_two_sent", 32'(ia_cyc_q.size() - ia0), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_mid_reset");
    exp_q.delete();
    exp_w_q.delete();
    for (int i = 0; i < 5; i++) wt_model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_s_ready", 32'(bus.s_ready), 32'd1);
    check("t6_state", 32'(bus.current_state_out), 32'd0);
    start_run(16'd1);
    push_sample(16'sd77);
    expect_drain();
    wait_done(300);

    repeat (3) tick();
    check("final_ia_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_tap_queue_empty", 32'(exp_w_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end
endmodule
